// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, bus ACK levels and data widths for the I2C target
package i2c_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam logic ACK = 1'b0;
    localparam logic NACK = 1'b1;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_HI, WR_HI_ACK, WR_LO, WR_LO_ACK,
        RD_HI, RD_HI_ACK, RD_LO, RD_LO_ACK, WAIT
    } state_t;
endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronizes scl/sda and flags scl edges plus START/STOP conditions
module i2c_bus_monitor (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [1:0] scl_sync, sda_sync;
    logic scl_p, sda_p, scl_s;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_p <= scl_sync[1];
            sda_p <= sda_sync[1];
        end
    end
    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
    assign scl_rise = scl_s && !scl_p;
    assign scl_fall = !scl_s && scl_p;
    // scl must be high on both samples so data changes around scl edges never look like START/STOP
    assign start = scl_s && scl_p && sda_p && !sda_s;
    assign stop = scl_s && scl_p && !sda_p && sda_s;
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target mapping 16-bit word reads/writes onto a user register file
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDRESS  = 7'h01,
    parameter int         CLOCK_FREQUENCY = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl,
    inout  wire               sda,
    output logic [BYTE_W-1:0] reg_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              wr_en,
    output logic              rd_en,
    input  logic [WORD_W-1:0] rd_data,
    output logic              busy
);
    state_t state, state_n;
    logic sda_s, scl_rise, scl_fall, start, stop;
    logic [3:0] bit_cnt;
    logic [BYTE_W-2:0] shift;
    logic [BYTE_W-1:0] hi_byte, rx_byte;
    logic [WORD_W-2:0] tx;
    logic sda_q, rw, ld, last_rise, byte_end;

    if (CLOCK_FREQUENCY <= 0) begin : g_bad_clock
        $error("CLOCK_FREQUENCY must be positive");
    end

    i2c_bus_monitor u_mon (
        .clk(clk),
        .reset(reset),
        .scl(scl),
        .sda(sda),
        .sda_s(sda_s),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start(start),
        .stop(stop)
    );

    assign rx_byte = {shift, sda_s};
    assign last_rise = scl_rise && bit_cnt == 4'd7;
    assign byte_end = scl_fall && bit_cnt == 4'd8;
    assign busy = state != IDLE;
    assign sda = sda_q ? 1'bz : 1'b0;

    always_comb begin
        state_n = state;
        if (stop)
            state_n = IDLE;
        else if (start)
            state_n = ADDR;
        else
            case (state)
                ADDR:      state_n = last_rise && shift != DEVICE_ADDRESS ? WAIT : byte_end ? ADDR_ACK : ADDR;
                ADDR_ACK:  state_n = scl_fall ? (rw ? RD_HI : REG) : ADDR_ACK;
                REG:       state_n = byte_end ? REG_ACK : REG;
                REG_ACK:   state_n = scl_fall ? WR_HI : REG_ACK;
                WR_HI:     state_n = byte_end ? WR_HI_ACK : WR_HI;
                WR_HI_ACK: state_n = scl_fall ? WR_LO : WR_HI_ACK;
                WR_LO:     state_n = byte_end ? WR_LO_ACK : WR_LO;
                WR_LO_ACK: state_n = scl_fall ? WR_HI : WR_LO_ACK;
                RD_HI:     state_n = byte_end ? RD_HI_ACK : RD_HI;
                RD_HI_ACK: state_n = scl_fall ? RD_LO : RD_HI_ACK;
                RD_LO:     state_n = byte_end ? RD_LO_ACK : RD_LO;
                RD_LO_ACK: state_n = scl_rise && sda_s == NACK ? WAIT : scl_fall ? RD_HI : RD_LO_ACK;
                default:   state_n = state;
            endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shift <= '0;
            hi_byte <= '0;
            tx <= '0;
            sda_q <= NACK;
            rw <= 1'b0;
            ld <= 1'b0;
            reg_addr <= '0;
            wr_data <= '0;
            wr_en <= 1'b0;
            rd_en <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            ld <= rd_en;
            bit_cnt <= start || stop || state_n != state ? 4'd0 : bit_cnt + {3'd0, scl_rise};
            if (scl_rise) shift <= rx_byte[BYTE_W-2:0];
            if (wr_en) reg_addr <= reg_addr + 8'd1;
            if (start || stop)
                sda_q <= NACK;
            else
                case (state)
                    ADDR: begin
                        if (last_rise) rw <= sda_s;
                        if (byte_end) sda_q <= ACK;
                    end
                    REG: begin
                        if (last_rise) reg_addr <= rx_byte;
                        if (byte_end) sda_q <= ACK;
                    end
                    WR_HI: begin
                        if (last_rise) hi_byte <= rx_byte;
                        if (byte_end) sda_q <= ACK;
                    end
                    WR_LO: begin
                        if (last_rise) begin
                            wr_data <= {hi_byte, rx_byte};
                            wr_en <= 1'b1;
                        end
                        if (byte_end) sda_q <= ACK;
                    end
                    ADDR_ACK: if (scl_fall) begin
                        sda_q <= NACK;
                        rd_en <= rw;
                    end
                    REG_ACK, WR_HI_ACK, WR_LO_ACK: if (scl_fall) sda_q <= NACK;
                    // ld marks the clk where the user's rd_data has become valid
                    RD_HI, RD_LO: if (ld) begin
                        tx <= rd_data[WORD_W-2:0];
                        sda_q <= rd_data[WORD_W-1];
                    end else if (scl_fall) begin
                        sda_q <= bit_cnt == 4'd8 ? NACK : tx[WORD_W-2];
                        if (bit_cnt != 4'd8) tx <= tx << 1;
                    end
                    RD_HI_ACK: if (scl_fall) begin
                        tx <= tx << 1;
                        sda_q <= tx[WORD_W-2];
                    end
                    RD_LO_ACK: if (scl_fall) begin
                        reg_addr <= reg_addr + 8'd1;
                        rd_en <= 1'b1;
                    end
                    default: sda_q <= NACK;
                endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged bus master with a transaction-level model of register writes and reads
module tb_i2c_slave;
    localparam int Q = 10;
    logic clk = 1'b0, reset = 1'b1, scl = 1'b1, m_sda = 1'b1;
    wire sda;
    logic [7:0] reg_addr;
    logic [15:0] wr_data, rd_data = 16'h0;
    logic wr_en, rd_en, busy;
    int total = 0, bad = 0;
    logic [15:0] mem [256];
    logic [23:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] ptr = 8'h00;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;
    always #5 clk = ~clk;

    i2c_slave #(.DEVICE_ADDRESS(7'h01), .CLOCK_FREQUENCY(100_000_000)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda), .reg_addr(reg_addr), .wr_data(wr_data),
        .wr_en(wr_en), .rd_en(rd_en), .rd_data(rd_data), .busy(busy)
    );

    // user register file: word available the clk after rd_en
    always @(posedge clk) if (rd_en) rd_data <= mem[reg_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got addr/data=%0h, no write expected", {reg_addr, wr_data});
            end else check("wr_word", {8'h0, reg_addr, wr_data}, {8'h0, exp_wr.pop_front()});
        end
        if (rd_en) begin
            if (exp_rd.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got addr=%0h, no read expected", reg_addr);
            end else check("rd_addr", {24'h0, reg_addr}, {24'h0, exp_rd.pop_front()});
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic b, output logic s);
        wait_clk(2); m_sda = b; wait_clk(Q - 2);
        scl = 1'b1; wait_clk(Q / 2); s = sda; wait_clk(Q / 2); scl = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic want, input string name);
        logic d;
        for (int i = 7; i >= 0; i--) put_bit(b[i], d);
        put_bit(1'b1, d);
        check(name, {31'h0, d}, {31'h0, want});
    endtask

    task automatic get(input logic mack, input logic [7:0] want, input string name);
        logic d;
        logic [7:0] v;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, d);
            v[i] = d;
        end
        put_bit(mack, d);
        check(name, {24'h0, v}, {24'h0, want});
    endtask

    task automatic start_c();
        m_sda = 1'b0; wait_clk(Q); scl = 1'b0;
    endtask

    task automatic rstart_c();
        wait_clk(2); m_sda = 1'b1; wait_clk(Q - 2); scl = 1'b1; wait_clk(Q); m_sda = 1'b0; wait_clk(Q); scl = 1'b0;
    endtask

    task automatic stop_c();
        wait_clk(2); m_sda = 1'b0; wait_clk(Q - 2); scl = 1'b1; wait_clk(Q); m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic settle();
        wait_clk(6);
        check("wr_pending", exp_wr.size(), 0);
        check("rd_pending", exp_rd.size(), 0);
        check("busy_after_stop", {31'h0, busy}, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sda"}, {31'h0, sda}, 1);
        check({tag, "_reg_addr"}, {24'h0, reg_addr}, 0);
        check({tag, "_wr_data"}, {16'h0, wr_data}, 0);
        check({tag, "_wr_en"}, {31'h0, wr_en}, 0);
        check({tag, "_rd_en"}, {31'h0, rd_en}, 0);
        check({tag, "_busy"}, {31'h0, busy}, 0);
    endtask

    initial begin
        logic [7:0] r, a8;
        logic [15:0] w;
        logic [15:0] words [3];
        int n;
        logic part, rw;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'hFF] = 16'h1234;
        mem[8'h00] = 16'h5678;
        mem[8'h20] = 16'h0000;
        wait_clk(4);
        check_reset_values("in_reset");
        reset = 1'b0;
        wait_clk(4);
        check_reset_values("after_reset");

        // single word write
        exp_wr.push_back({8'h10, 16'hBEEF});
        mem[8'h10] = 16'hBEEF;
        start_c();
        send(8'h02, 1'b0, "w_addr_ack");
        send(8'h10, 1'b0, "w_reg_ack");
        send(8'hBE, 1'b0, "w_hi_ack");
        send(8'hEF, 1'b0, "w_lo_ack");
        stop_c();
        settle();
        check("ptr_after_write", {24'h0, reg_addr}, 32'h11);

        // burst read across the 0xFF -> 0x00 wrap
        exp_rd.push_back(8'hFF);
        exp_rd.push_back(8'h00);
        start_c();
        send(8'h02, 1'b0, "r_addr_w_ack");
        send(8'hFF, 1'b0, "r_reg_ack");
        rstart_c();
        send(8'h03, 1'b0, "r_addr_r_ack");
        get(1'b0, 8'h12, "r_b0");
        get(1'b0, 8'h34, "r_b1");
        get(1'b0, 8'h56, "r_b2");
        get(1'b1, 8'h78, "r_b3");
        stop_c();
        settle();

        // foreign address is never acknowledged
        start_c();
        send(8'h44, 1'b1, "foreign_addr_nack");
        check("foreign_busy", {31'h0, busy}, 1);
        send(8'h10, 1'b1, "foreign_data_nack");
        stop_c();
        settle();

        // STOP after only the high data byte
        start_c();
        send(8'h02, 1'b0, "p_addr_ack");
        send(8'h30, 1'b0, "p_reg_ack");
        send(8'hAA, 1'b0, "p_hi_ack");
        stop_c();
        settle();
        check("partial_ptr", {24'h0, reg_addr}, 32'h30);

        // reset while the target drives a 0 data bit
        exp_rd.push_back(8'h20);
        start_c();
        send(8'h02, 1'b0, "x_addr_w_ack");
        send(8'h20, 1'b0, "x_reg_ack");
        rstart_c();
        send(8'h03, 1'b0, "x_addr_r_ack");
        wait_clk(7);
        check("x_drive_low", {31'h0, sda}, 0);
        #2 reset = 1'b1;
        #1 check_reset_values("mid_read_reset");
        @(negedge clk) reset = 1'b0;
        send(8'h02, 1'b1, "x_no_start_nack");
        check("x_idle_busy", {31'h0, busy}, 0);
        stop_c();
        settle();
        ptr = 8'h00;

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    r = 8'($urandom);
                    n = $urandom_range(0, 2);
                    part = 1'($urandom);
                    for (int i = 0; i < n; i++) begin
                        words[i] = 16'($urandom);
                        a8 = r + 8'(i);
                        exp_wr.push_back({a8, words[i]});
                        mem[a8] = words[i];
                    end
                    start_c();
                    send(8'h02, 1'b0, "rw_addr_ack");
                    send(r, 1'b0, "rw_reg_ack");
                    for (int i = 0; i < n; i++) begin
                        w = words[i];
                        send(w[15:8], 1'b0, "rw_hi_ack");
                        send(w[7:0], 1'b0, "rw_lo_ack");
                    end
                    if (part) send(8'($urandom), 1'b0, "rw_part_ack");
                    stop_c();
                    settle();
                    ptr = r + 8'(n);
                end
                1: begin
                    start_c();
                    if ($urandom_range(0, 1) == 1) begin
                        ptr = 8'($urandom);
                        send(8'h02, 1'b0, "rr_addr_w_ack");
                        send(ptr, 1'b0, "rr_reg_ack");
                        rstart_c();
                    end
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) exp_rd.push_back(ptr + 8'(i));
                    send(8'h03, 1'b0, "rr_addr_r_ack");
                    for (int i = 0; i < n; i++) begin
                        w = mem[ptr + 8'(i)];
                        get(1'b0, w[15:8], "rr_hi");
                        get(i == n - 1, w[7:0], "rr_lo");
                    end
                    stop_c();
                    settle();
                    ptr = ptr + 8'(n - 1);
                end
                default: begin
                    a8 = 8'($urandom_range(2, 127));
                    rw = 1'($urandom);
                    start_c();
                    send({a8[6:0], rw}, 1'b1, "rx_addr_nack");
                    check("rx_busy", {31'h0, busy}, 1);
                    send(8'($urandom), 1'b1, "rx_data_nack");
                    stop_c();
                    settle();
                end
            endcase
            check("ptr_model", {24'h0, reg_addr}, {24'h0, ptr});
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
